// File: rtl/i2s_rx_framer.sv
`default_nettype none
// ============================================================================
// Module      : i2s_rx_framer
// Description : I2S / left-justified serial receiver that frames WS slots,
//               pairs left/right words and flags slot-length violations.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_framer #(
    parameter int DATA_WIDTH     = 8,
    parameter int SLOT_WIDTH     = 16,
    parameter bit LEFT_JUSTIFIED = 1'b0,
    parameter bit WS_LEFT_LEVEL  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bit_en,
    input  logic                  ws,
    input  logic                  data_in,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  sample_valid,
    output logic                  frame_error
);

    localparam int                 c_cnt_w    = $clog2(SLOT_WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_slot_max = c_cnt_w'(SLOT_WIDTH);
    // Counter value on the instant that carries the word's LSB.
    localparam logic [c_cnt_w-1:0] c_last_bit = LEFT_JUSTIFIED ? c_cnt_w'(DATA_WIDTH - 1)
                                                               : c_cnt_w'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SHIFT = 2'd2,
        ST_SKIP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    primed_q, primed_d;
    logic                    ws_prev_q, ws_prev_d;
    logic                    chan_left_q, chan_left_d;
    logic [c_cnt_w-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   pend_q, pend_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [DATA_WIDTH-1:0]   left_q, left_d;
    logic [DATA_WIDTH-1:0]   right_q, right_d;
    logic                    sample_valid_q, sample_valid_d;
    logic                    frame_error_q, frame_error_d;

    logic                    ws_edge;
    logic                    captured;
    logic [c_cnt_w-1:0]      cnt_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_SYNC;
            primed_q       <= 1'b0;
            ws_prev_q      <= 1'b0;
            chan_left_q    <= 1'b0;
            cnt_q          <= '0;
            shift_q        <= '0;
            pend_q         <= '0;
            pend_valid_q   <= 1'b0;
            left_q         <= '0;
            right_q        <= '0;
            sample_valid_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            primed_q       <= primed_d;
            ws_prev_q      <= ws_prev_d;
            chan_left_q    <= chan_left_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            pend_q         <= pend_d;
            pend_valid_q   <= pend_valid_d;
            left_q         <= left_d;
            right_q        <= right_d;
            sample_valid_q <= sample_valid_d;
            frame_error_q  <= frame_error_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        primed_d       = primed_q;
        ws_prev_d      = ws_prev_q;
        chan_left_d    = chan_left_q;
        cnt_d          = cnt_q;
        shift_d        = shift_q;
        pend_d         = pend_q;
        pend_valid_d   = pend_valid_q;
        left_d         = left_q;
        right_d        = right_q;
        sample_valid_d = 1'b0;
        frame_error_d  = 1'b0;
        ws_edge        = 1'b0;
        captured       = 1'b0;
        cnt_inc        = (cnt_q == c_slot_max) ? cnt_q : cnt_q + c_cnt_w'(1);

        if (bit_en) begin
            primed_d  = 1'b1;
            ws_prev_d = ws;
            ws_edge   = primed_q && (ws != ws_prev_q);

            if (ws_edge) begin
                cnt_d       = '0;
                chan_left_d = (ws == WS_LEFT_LEVEL);
                if (state_q == ST_DELAY || state_q == ST_SHIFT) begin
                    frame_error_d = 1'b1;
                end
                if (LEFT_JUSTIFIED) begin
                    shift_d  = DATA_WIDTH'(data_in);
                    captured = 1'b1;
                    state_d  = ST_SHIFT;
                end else begin
                    // The bit sampled on the edge still belongs to the previous slot.
                    shift_d = '0;
                    state_d = ST_DELAY;
                end
            end else begin
                cnt_d = cnt_inc;
                if (state_q == ST_DELAY || state_q == ST_SHIFT) begin
                    shift_d  = DATA_WIDTH'({shift_q, data_in});
                    captured = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end

            if (captured && cnt_d == c_last_bit) begin
                state_d = ST_SKIP;
                if (chan_left_d) begin
                    pend_d       = shift_d;
                    pend_valid_d = 1'b1;
                end else if (pend_valid_q && !frame_error_d) begin
                    left_d         = pend_q;
                    right_d        = shift_d;
                    sample_valid_d = 1'b1;
                    pend_valid_d   = 1'b0;
                end
            end

            // Over-long slot overrides any completion on the same instant.
            if (!ws_edge && state_q != ST_SYNC && cnt_inc == c_slot_max) begin
                frame_error_d  = 1'b1;
                sample_valid_d = 1'b0;
                left_d         = left_q;
                right_d        = right_q;
                pend_valid_d   = 1'b0;
                state_d        = ST_SYNC;
            end
        end
    end

    assign left_data    = left_q;
    assign right_data   = right_q;
    assign sample_valid = sample_valid_q;
    assign frame_error  = frame_error_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_rx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_rx_framer
// Description : Randomized self-checking bench for i2s_rx_framer (standard and
//               left-justified instances fed from one serial stream).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_rx_framer;

    localparam int DW = 8;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          reset, bit_en, ws, data_in;
    logic [DW-1:0] left_s, right_s, left_l, right_l;
    logic          sv_s, fe_s, sv_l, fe_l;

    always #5 clk = ~clk;

    i2s_rx_framer #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .LEFT_JUSTIFIED(1'b0), .WS_LEFT_LEVEL(1'b0)) dut_std (
        .clk(clk), .reset(reset), .bit_en(bit_en), .ws(ws), .data_in(data_in),
        .left_data(left_s), .right_data(right_s), .sample_valid(sv_s), .frame_error(fe_s));

    i2s_rx_framer #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .LEFT_JUSTIFIED(1'b1), .WS_LEFT_LEVEL(1'b0)) dut_lj (
        .clk(clk), .reset(reset), .bit_en(bit_en), .ws(ws), .data_in(data_in),
        .left_data(left_l), .right_data(right_l), .sample_valid(sv_l), .frame_error(fe_l));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: index 0 = standard I2S, index 1 = left-justified.
    // Each slot's samples are buffered; words are read at fixed offsets.
    bit            m_primed[2], m_prev[2], m_sync[2], m_done[2], m_left_ch[2], m_pend_v[2];
    int            m_len[2];
    bit            m_buf[2][128];
    logic [DW-1:0] m_pend[2], e_left[2], e_right[2];
    bit            e_sv[2], e_fe[2];

    int sv_cnt[2];
    int fe_cnt[2];
    int slot_idx = 0;
    int fe_at    = -1;
    int gap_min  = 4;
    int gap_max  = 4;
    bit cur_ws   = 1'b1;

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_primed[m] = 0; m_prev[m] = 0; m_sync[m] = 0; m_done[m] = 0;
            m_left_ch[m] = 0; m_pend_v[m] = 0; m_len[m] = 0; m_pend[m] = '0;
            e_left[m] = '0; e_right[m] = '0; e_sv[m] = 0; e_fe[m] = 0;
        end
    endtask

    task automatic model_step(input int m, input bit w, input bit d);
        int            off;
        logic [DW-1:0] word;
        off     = (m == 1) ? 0 : 1;
        e_sv[m] = 0;
        e_fe[m] = 0;
        if (m_primed[m] && w != m_prev[m]) begin
            if (m_sync[m] && !m_done[m]) e_fe[m] = 1;
            m_sync[m]    = 1;
            m_done[m]    = 0;
            m_len[m]     = 0;
            m_left_ch[m] = (w == 1'b0);
        end
        m_primed[m] = 1;
        m_prev[m]   = w;
        if (m_len[m] < 128) begin
            m_buf[m][m_len[m]] = d;
            m_len[m]++;
        end
        if (m_sync[m] && m_len[m] == SW + 1) begin
            e_fe[m]     = 1;
            m_sync[m]   = 0;
            m_pend_v[m] = 0;
        end else if (m_sync[m] && !m_done[m] && m_len[m] == DW + off) begin
            m_done[m] = 1;
            word      = '0;
            for (int i = 0; i < DW; i++) word = {word[DW-2:0], m_buf[m][off+i]};
            if (m_left_ch[m]) begin
                m_pend[m]   = word;
                m_pend_v[m] = 1;
            end else if (m_pend_v[m] && !e_fe[m]) begin
                e_left[m]   = m_pend[m];
                e_right[m]  = word;
                e_sv[m]     = 1;
                m_pend_v[m] = 0;
            end
        end
    endtask

    task automatic tick(input bit en, input bit w, input bit d, input bit rst);
        reset   = rst;
        bit_en  = en;
        ws      = w;
        data_in = d;
        if (rst) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (en) model_step(m, w, d);
                else begin
                    e_sv[m] = 0;
                    e_fe[m] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        check_eq("std_out", {14'b0, sv_s, fe_s, left_s, right_s},
                 {14'b0, e_sv[0], e_fe[0], e_left[0], e_right[0]});
        check_eq("lj_out", {14'b0, sv_l, fe_l, left_l, right_l},
                 {14'b0, e_sv[1], e_fe[1], e_left[1], e_right[1]});
        if (sv_s) sv_cnt[0]++;
        if (sv_l) sv_cnt[1]++;
        if (fe_s) begin
            fe_cnt[0]++;
            fe_at = slot_idx;
        end
        if (fe_l) fe_cnt[1]++;
    endtask

    task automatic instant(input bit w, input bit d);
        int g;
        g = int'($urandom_range(gap_max, gap_min));
        for (int k = 1; k < g; k++) tick(1'b0, 1'($urandom), 1'($urandom), 1'b0);
        tick(1'b1, w, d, 1'b0);
    endtask

    task automatic send_slot(input bit w, input logic [DW-1:0] word, input int nbits, input bit lj_fmt);
        int off;
        off = lj_fmt ? 0 : 1;
        for (int i = 0; i < nbits; i++) begin
            bit d;
            slot_idx = i;
            if (i >= off && i - off < DW) d = word[DW-1-(i-off)];
            else d = 1'($urandom);
            instant(w, d);
        end
        cur_ws = w;
    endtask

    initial begin
        int sv0, sv1, fe0, fe1;
        model_reset();

        // Reset overrides bit_en.
        for (int k = 0; k < 3; k++) tick(1'b1, 1'($urandom), 1'($urandom), 1'b1);
        check_eq("rst_outputs", {14'b0, sv_s, fe_s, left_s, right_s}, 32'd0);

        // Standard pair A5/3C, bit_en every 4th clk.
        sv0 = sv_cnt[0];
        send_slot(1'b1, 8'h00, 3, 1'b0);
        send_slot(1'b0, 8'hA5, 16, 1'b0);
        send_slot(1'b1, 8'h3C, 16, 1'b0);
        check_eq("r032_sv_count", 32'(sv_cnt[0] - sv0), 32'd1);
        check_eq("r032_left", 32'(left_s), 32'hA5);
        check_eq("r032_right", 32'(right_s), 32'h3C);

        // Left-justified pair 81/7E.
        sv1 = sv_cnt[1]; fe1 = fe_cnt[1];
        send_slot(1'b0, 8'h81, 16, 1'b1);
        send_slot(1'b1, 8'h7E, 16, 1'b1);
        check_eq("r033_sv_count", 32'(sv_cnt[1] - sv1), 32'd1);
        check_eq("r033_fe_count", 32'(fe_cnt[1] - fe1), 32'd0);
        check_eq("r033_left", 32'(left_l), 32'h81);
        check_eq("r033_right", 32'(right_l), 32'h7E);

        // Short left slot, orphan right word, then a clean pair.
        sv0 = sv_cnt[0]; fe0 = fe_cnt[0];
        send_slot(1'b0, 8'hFF, 6, 1'b0);
        send_slot(1'b1, 8'h11, 16, 1'b0);
        check_eq("r034_fe_count", 32'(fe_cnt[0] - fe0), 32'd1);
        check_eq("r034_no_sv", 32'(sv_cnt[0] - sv0), 32'd0);
        send_slot(1'b0, 8'h22, 16, 1'b0);
        send_slot(1'b1, 8'h33, 16, 1'b0);
        check_eq("r034_sv_count", 32'(sv_cnt[0] - sv0), 32'd1);
        check_eq("r034_pair", {16'b0, left_s, right_s}, 32'h2233);

        // WS held for 21 instants: error on the 16th instant after the edge.
        sv0 = sv_cnt[0]; fe0 = fe_cnt[0]; fe_at = -1;
        send_slot(1'b0, 8'h44, 21, 1'b0);
        check_eq("r035_fe_count", 32'(fe_cnt[0] - fe0), 32'd1);
        check_eq("r035_fe_at", 32'(fe_at), 32'd16);
        send_slot(1'b1, 8'h55, 16, 1'b0);
        check_eq("r035_no_sv", 32'(sv_cnt[0] - sv0), 32'd0);
        send_slot(1'b0, 8'h66, 16, 1'b0);
        send_slot(1'b1, 8'h77, 16, 1'b0);
        check_eq("r035_sv_count", 32'(sv_cnt[0] - sv0), 32'd1);
        check_eq("r035_pair", {16'b0, left_s, right_s}, 32'h6677);

        // Reset in the middle of a right word after a complete left.
        send_slot(1'b0, 8'hFF, 16, 1'b0);
        send_slot(1'b1, 8'h00, 6, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("r036_zero", {16'b0, left_s, right_s}, 32'd0);
        sv0 = sv_cnt[0];
        send_slot(1'b1, 8'h00, 3, 1'b0);
        send_slot(1'b0, 8'h12, 16, 1'b0);
        send_slot(1'b1, 8'h34, 16, 1'b0);
        check_eq("r036_sv_count", 32'(sv_cnt[0] - sv0), 32'd1);
        check_eq("r036_pair", {16'b0, left_s, right_s}, 32'h1234);

        // Irregular bit_en gaps.
        gap_min = 1; gap_max = 7;
        sv0 = sv_cnt[0];
        send_slot(1'b0, 8'hC3, 16, 1'b0);
        send_slot(1'b1, 8'h5A, 16, 1'b0);
        check_eq("r037_sv_count", 32'(sv_cnt[0] - sv0), 32'd1);
        check_eq("r037_pair", {16'b0, left_s, right_s}, 32'hC35A);

        // Random slots, lengths, formats and occasional resets.
        gap_min = 1; gap_max = 3;
        for (int n = 0; n < 150; n++) begin
            bit w;
            int nb;
            w  = ($urandom_range(9, 0) < 8) ? ~cur_ws : cur_ws;
            nb = ($urandom_range(9, 0) < 6) ? 16 : int'($urandom_range(20, 3));
            send_slot(w, 8'($urandom), nb, 1'($urandom));
            if ($urandom_range(29, 0) == 0) tick(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2s_rx_framer.md
I2S_RX_FRAMER -- requirements
Module: i2s_rx_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: captured sample width per channel, legal range 1..32.
REQ-002 Parameter SLOT_WIDTH, default 16: maximum bits per WS half-period, legal range DATA_WIDTH..64.
REQ-003 Parameter LEFT_JUSTIFIED, default 0: 0 = standard I2S (MSB one bit after WS edge); 1 = MSB on first bit after WS edge.
REQ-004 Parameter WS_LEFT_LEVEL, default 0: WS level that denotes the left channel.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 bit_en  input  1  one-clk strobe marking a bit-clock sampling instant; ws and data_in are sampled only when it is high.
REQ-008 ws  input  1  word select.
REQ-009 data_in  input  1  serial data, MSB first.
REQ-010 left_data  output  DATA_WIDTH  last completed left sample of a pair.
REQ-011 right_data  output  DATA_WIDTH  last completed right sample of a pair.
REQ-012 sample_valid  output  1  one-clk pulse when left_data/right_data update.
REQ-013 frame_error  output  1  one-clk pulse on a slot-length violation.

Function
REQ-014 Sampling instant = clk edge with bit_en=1; no state, counter or output changes on other edges except pulse deassertion.
REQ-015 WS edge = sampled ws differs from previous sampled ws; detection is disabled until one ws sample has been taken after reset (primed flag).
REQ-016 States: SYNC, DELAY, SHIFT, SKIP; reset state SYNC.
REQ-017 SYNC: on WS edge, latch channel = (ws == WS_LEFT_LEVEL ? left : right), clear shift register and bit counter; go DELAY if LEFT_JUSTIFIED=0, else go SHIFT and shift in that instant's data_in as the MSB.
REQ-018 DELAY: lasts exactly one sampling instant (data_in ignored), then SHIFT.
REQ-019 SHIFT: per instant shift register <= {shift[DATA_WIDTH-2:0], data_in}; after the DATA_WIDTH-th bit, store the word for the latched channel and go SKIP.
REQ-020 SKIP: ignore data_in until the next WS edge, then behave as REQ-017 (restart capture for the new channel).
REQ-021 Bit counter counts sampling instants since the last WS edge, width clog2(SLOT_WIDTH+1), saturating; it never wraps.
REQ-022 Completed left word is held in a pending register with pending flag set; a later left completion overwrites it.
REQ-023 Right completion with pending set: left_data <= pending, right_data <= new word, sample_valid = 1 on the next clk cycle only, pending cleared.
REQ-024 Right completion without pending: word discarded, no sample_valid, outputs unchanged.
REQ-025 Short slot: WS edge in DELAY or SHIFT before DATA_WIDTH bits captured -> partial word discarded, frame_error pulses one clk cycle, capture restarts per REQ-017 on the same instant.
REQ-026 Long slot: counter reaches SLOT_WIDTH with no WS edge -> frame_error pulses one cycle, pending cleared, state SYNC.
REQ-027 In standard mode, a DATA_WIDTH-bit capture needs DATA_WIDTH+1 instants; if SLOT_WIDTH < DATA_WIDTH+1, every slot raises REQ-025 or REQ-026 (configuration error, not masked).
REQ-028 sample_valid and frame_error never assert in the same cycle; if both conditions arise on one instant, frame_error wins and no sample is emitted.
REQ-029 Latency: sample_valid rises the clk cycle after the instant sampling the right word's LSB.

Reset
REQ-030 reset=1 at any clk edge: state SYNC, primed, pending, counter, shift register cleared; left_data=0, right_data=0, sample_valid=0, frame_error=0, overriding bit_en.
REQ-031 Reset mid-word discards all partial and pending data; first sample_valid after release requires a complete new left then right word.

Verification
REQ-032 DATA_WIDTH=8, SLOT_WIDTH=16, standard mode, bit_en every 4th clk, left 0xA5, right 0x3C -> one sample_valid pulse, left_data=0xA5, right_data=0x3C.
REQ-033 LEFT_JUSTIFIED=1, same frame left 0x81, right 0x7E -> left_data=0x81, right_data=0x7E, no frame_error.
REQ-034 WS toggles after 5 left bits (standard, DATA_WIDTH=8) -> frame_error one cycle; following valid right 0x11 with no pending left -> no sample_valid; next full pair emits normally.
REQ-035 WS held constant 20 instants, SLOT_WIDTH=16 -> frame_error pulse at instant 16, state SYNC, no sample_valid until a new edge plus full left/right pair.
REQ-036 reset asserted mid right word after complete left 0xFF -> outputs 0, next pair 0x12/0x34 yields exactly one sample_valid with those values.
REQ-037 Irregular bit_en gaps (1..7 clks) with pair 0xC3/0x5A -> same result as REQ-032; outputs stable between instants.
